// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the 4-digit seven-segment scanner.
// Contents:
//   NUM_DIGITS, SEG_BLANK, AN_OFF    display geometry and idle levels
//   SEG_DP .. SEG_G                  bit positions inside one packed segment byte
//   phase_e                          position within one digit step
package seven_seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [7:0]  SEG_BLANK  = 8'hFF;
  localparam logic [3:0]  AN_OFF     = 4'b1111;

  // Segment bit positions within a byte (active-low on the pins).
  localparam int unsigned SEG_DP = 0;
  localparam int unsigned SEG_A  = 1;
  localparam int unsigned SEG_B  = 2;
  localparam int unsigned SEG_C  = 3;
  localparam int unsigned SEG_D  = 4;
  localparam int unsigned SEG_E  = 5;
  localparam int unsigned SEG_F  = 6;
  localparam int unsigned SEG_G  = 7;

  typedef enum logic [1:0] {
    S_BLANK,
    S_ON,
    S_OFF
  } phase_e;

  // Active-low anode pattern selecting a single digit.
  function automatic logic [3:0] anode_sel(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Timebase for the scanner: per-step cycle counter, digit index and blink phase.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   step_cnt_o      cycle position inside the current digit step (0..STEP_DIV-1)
//   idx_o           digit currently being scanned (0 = ones)
//   frame_wrap_o    high on the last cycle of the thousands step (word latch point)
//   blink_phase_o   toggles every BLINK_FRAMES frames; 1 = blinking digits dark
module scan_tick_gen
  import seven_seg_pkg::*;
#(
  parameter int unsigned STEP_DIV     = 100000,
  parameter int unsigned BLINK_FRAMES = 125,
  localparam int unsigned CW          = $clog2(STEP_DIV),
  localparam int unsigned FW          = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] step_cnt_o,
  output logic [1:0]    idx_o,
  output logic          frame_wrap_o,
  output logic          blink_phase_o
);

  localparam logic [CW-1:0] STEP_LAST  = CW'(STEP_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [1:0]    IDX_LAST   = 2'(NUM_DIGITS - 1);

  logic [CW-1:0] step_cnt_q, step_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic          wrap, frame_wrap;

  assign wrap       = (step_cnt_q == STEP_LAST);
  assign frame_wrap = wrap && (idx_q == IDX_LAST);

  always_comb begin
    step_cnt_d    = wrap ? '0 : step_cnt_q + CW'(1);
    idx_d         = idx_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_LAST) ? 2'd0 : idx_q + 2'd1;
    end
    if (frame_wrap) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt_q    <= '0;
      idx_q         <= IDX_LAST;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      step_cnt_q    <= step_cnt_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign step_cnt_o    = step_cnt_q;
  assign idx_o         = idx_q;
  assign frame_wrap_o  = frame_wrap;
  assign blink_phase_o = blink_phase_q;

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a common-anode 4-digit seven-segment display.
// The packed segment word is latched once per frame so a mid-scan change never tears.
// Each digit step is: dead time (all anodes off), lit window sized by brightness, dark rest.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   sevenSeg      packed active-low segments, [31:24] leftmost .. [7:0] ones
//   brightness    0 = dimmest, 7 = full
//   blink_mask    bit i blinks digit i (0 = ones)
//   an            active-low anodes, an[3] = leftmost
//   seg           active-low cathodes, same bit order as a sevenSeg byte
//   frame_start   one-cycle pulse when a freshly latched frame begins
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int unsigned STEP_DIV     = 100000,
  parameter int unsigned BLANK_CYC    = 2000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sevenSeg,
  input  logic [2:0]  brightness,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        frame_start
);

  localparam int unsigned CW  = $clog2(STEP_DIV);
  // Three extra bits so active*(brightness+1) cannot overflow before the >>3.
  localparam int unsigned OLW = CW + 3;
  localparam logic [OLW-1:0] ACTIVE_CYC = OLW'(STEP_DIV - BLANK_CYC);
  localparam logic [OLW-1:0] BLANK_END  = OLW'(BLANK_CYC);

  logic [CW-1:0]  step_cnt;
  logic [1:0]     idx;
  logic           frame_wrap;
  logic           blink_phase;

  logic [31:0]    shadow_q, shadow_d;
  logic [OLW-1:0] on_len_q, on_len_d;
  logic [3:0]     an_q, an_d;
  logic [7:0]     seg_q, seg_d;
  logic           frame_start_q, frame_start_d;

  logic [OLW-1:0] on_prod;
  logic [OLW-1:0] step_pos;
  phase_e         phase;
  logic           lit;

  scan_tick_gen #(
    .STEP_DIV     (STEP_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_tick (
    .clk           (clk),
    .rst           (rst),
    .step_cnt_o    (step_cnt),
    .idx_o         (idx),
    .frame_wrap_o  (frame_wrap),
    .blink_phase_o (blink_phase)
  );

  assign step_pos = OLW'(step_cnt);
  assign on_prod  = ACTIVE_CYC * (OLW'(brightness) + OLW'(1));

  always_comb begin
    if (step_pos < BLANK_END) begin
      phase = S_BLANK;
    end else if (step_pos < BLANK_END + on_len_q) begin
      phase = S_ON;
    end else begin
      phase = S_OFF;
    end
  end

  assign lit = (phase == S_ON) && !(blink_phase && blink_mask[idx]);

  always_comb begin
    shadow_d      = frame_wrap ? sevenSeg : shadow_q;
    // Brightness only takes effect at a step boundary so a step is never cut short.
    on_len_d      = (step_cnt == '0) ? (on_prod >> 3) : on_len_q;
    frame_start_d = frame_wrap;
    an_d          = AN_OFF;
    seg_d         = SEG_BLANK;
    if (lit) begin
      // Anode and byte are chosen from the same idx, so they can never disagree.
      an_d  = anode_sel(idx);
      seg_d = shadow_q[{idx, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q      <= 32'hFFFF_FFFF;
      on_len_q      <= '0;
      an_q          <= AN_OFF;
      seg_q         <= SEG_BLANK;
      frame_start_q <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      on_len_q      <= on_len_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;

  localparam int unsigned SD = 16;
  localparam int unsigned BC = 2;
  localparam int unsigned BF = 2;
  localparam int unsigned FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] seven_seg;
  logic [2:0]  brightness;
  logic [3:0]  blink_mask;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_start;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .STEP_DIV     (SD),
    .BLANK_CYC    (BC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sevenSeg    (seven_seg),
    .brightness  (brightness),
    .blink_mask  (blink_mask),
    .an          (an),
    .seg         (seg),
    .frame_start (frame_start)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: t = clock edges since reset released; everything else follows
  // from t by division (step number, digit, frames completed, blink half-period).
  int unsigned t;
  logic [31:0] m_shadow;
  int unsigned m_on_len;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic tick(input logic do_rst);
    int unsigned p, s, idx, n, ph, new_on;
    bit          lit;
    logic [3:0]  one_hot, exp_an;
    logic [7:0]  exp_seg;
    logic        exp_fs;
    logic [31:0] sh_prev, new_sh;
    sh_prev = m_shadow;
    new_on  = 0;
    new_sh  = 32'hFFFF_FFFF;
    if (do_rst) begin
      exp_an  = 4'hF;
      exp_seg = 8'hFF;
      exp_fs  = 1'b0;
    end else begin
      p   = t % SD;
      s   = t / SD;
      idx = (3 + s) % 4;
      n   = (s + 3) / 4;
      ph  = (n / BF) % 2;
      lit = (p >= BC) && (p < BC + m_on_len) && !(ph == 1 && blink_mask[idx]);
      one_hot = 4'b0001 << idx;
      exp_an  = lit ? ~one_hot : 4'hF;
      exp_seg = lit ? m_shadow[8*idx +: 8] : 8'hFF;
      exp_fs  = (p == SD - 1) && (idx == 3);
      new_on  = (p == 0) ? ((SD - BC) * (int'(brightness) + 1)) >> 3 : m_on_len;
      new_sh  = exp_fs ? seven_seg : m_shadow;
    end
    rst = do_rst;
    @(posedge clk);
    #1;
    if (do_rst) begin
      t        = 0;
      m_shadow = 32'hFFFF_FFFF;
      m_on_len = 0;
    end else begin
      t        = t + 1;
      m_shadow = new_sh;
      m_on_len = new_on;
    end
    check("an", {28'd0, an}, {28'd0, exp_an});
    check("seg", {24'd0, seg}, {24'd0, exp_seg});
    check("frame_start", {31'd0, frame_start}, {31'd0, exp_fs});
    check("an_onehot", ($countones(~an) <= 1) ? 32'd1 : 32'd0, 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (an[k] == 1'b0) check("ghost_seg", {24'd0, seg}, {24'd0, sh_prev[8*k +: 8]});
    end
  endtask

  task automatic run_until_an(input logic [3:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1'b0);
      if (an == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [2:0] bri;
    int         lead;
    int         lit;
    int         tail;
  } bri_vec_t;

  initial begin
    bri_vec_t    vecs[3];
    logic [11:0] seq[$];
    logic [11:0] exp_seq[5];
    logic [3:0]  prev_an;
    int          fs_cnt, e_cnt, first_e;
    int          lead, lit_n, tail;
    bit          ok;
    bit          lit3[8], lit0[8];
    int          n_lit3, n_lit0, n_period;

    vecs[0] = '{bri: 3'd7, lead: 2, lit: 14, tail: 0};
    vecs[1] = '{bri: 3'd3, lead: 2, lit: 7, tail: 7};
    vecs[2] = '{bri: 3'd0, lead: 2, lit: 1, tail: 13};
    exp_seq[0] = 12'h7FF;
    exp_seq[1] = 12'hE61;
    exp_seq[2] = 12'hD49;
    exp_seq[3] = 12'hBF3;
    exp_seq[4] = 12'h781;

    t          = 0;
    m_shadow   = 32'hFFFF_FFFF;
    m_on_len   = 0;
    seven_seg  = 32'h81F3_4961;
    brightness = 3'd7;
    blink_mask = 4'b0000;
    rst        = 1'b1;

    // Reset held, then first frame of "0123".
    repeat (5) tick(1'b1);
    prev_an = 4'hF;
    fs_cnt  = 0;
    e_cnt   = 0;
    first_e = -1;
    for (int i = 0; i < int'(5 * SD); i++) begin
      tick(1'b0);
      if (i < 20 && frame_start) fs_cnt++;
      if (an == 4'b1110) begin
        e_cnt++;
        if (first_e < 0) first_e = i;
      end
      if (an != 4'hF && an != prev_an) seq.push_back({an, seg});
      prev_an = an;
    end
    check("first_frame_start_pulses", fs_cnt, 1);
    check("ones_lit_cycles", e_cnt, 14);
    check("ones_first_lit_cycle", first_e, 18);
    check("scan_order_len", seq.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < seq.size()) check("scan_order", {20'd0, seq[k]}, {20'd0, exp_seq[k]});
    end

    // Brightness table: dark lead, lit window, dark tail for one full step.
    foreach (vecs[v]) begin
      brightness = vecs[v].bri;
      tick(1'b0);
      while (t % SD != 0) tick(1'b0);
      lead  = 0;
      lit_n = 0;
      tail  = 0;
      for (int i = 0; i < int'(SD); i++) begin
        tick(1'b0);
        if (an != 4'hF) lit_n++;
        else if (lit_n == 0) lead++;
        else tail++;
      end
      check("bri_lead", lead, vecs[v].lead);
      check("bri_lit", lit_n, vecs[v].lit);
      check("bri_tail", tail, vecs[v].tail);
    end

    // Word change in the middle of the tens step must not tear the current frame.
    brightness = 3'd7;
    while (!((t % SD == 8) && ((3 + t / SD) % 4 == 1))) tick(1'b0);
    seven_seg = 32'h0000_0000;
    run_until_an(4'b0111, int'(2 * FRAME), ok);
    check("tear_thousands_seen", ok, 1);
    if (ok) check("tear_thousands_old", {24'd0, seg}, 32'h81);
    run_until_an(4'b1110, int'(2 * FRAME), ok);
    check("tear_ones_seen", ok, 1);
    if (ok) check("tear_ones_new", {24'd0, seg}, 32'h00);

    // Blink on the leftmost digit: lit two frames, dark two frames.
    seven_seg  = 32'h81F3_4961;
    blink_mask = 4'b1000;
    while (t % FRAME != SD) tick(1'b0);
    for (int f = 0; f < 8; f++) begin
      lit3[f] = 1'b0;
      lit0[f] = 1'b0;
      for (int i = 0; i < int'(FRAME); i++) begin
        tick(1'b0);
        if (an == 4'b0111) lit3[f] = 1'b1;
        if (an == 4'b1110) lit0[f] = 1'b1;
      end
    end
    n_lit3   = 0;
    n_lit0   = 0;
    n_period = 0;
    for (int f = 0; f < 8; f++) begin
      n_lit3 += int'(lit3[f]);
      n_lit0 += int'(lit0[f]);
      if (f < 6 && lit3[f] != lit3[f+2]) n_period++;
    end
    check("blink_lit_frames", n_lit3, 4);
    check("blink_other_digit", n_lit0, 8);
    check("blink_period", n_period, 6);
    blink_mask = 4'b0000;

    // Reset while the hundreds digit is lit.
    run_until_an(4'b1011, int'(2 * FRAME), ok);
    check("rst_hundreds_seen", ok, 1);
    tick(1'b1);
    check("rst_an_dark", {28'd0, an}, 32'hF);
    check("rst_seg_dark", {24'd0, seg}, 32'hFF);
    ok = 1'b0;
    for (int i = 0; i < int'(3 * SD); i++) begin
      tick(1'b0);
      if (seg != 8'hFF) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_first_visible_seen", ok, 1);
    if (ok) check("rst_first_visible_idx0", {28'd0, an}, 32'hE);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) brightness = 3'($urandom_range(7));
      if ($urandom_range(39) == 0) blink_mask = 4'($urandom_range(15));
      if ($urandom_range(29) == 0) seven_seg = $urandom;
      tick($urandom_range(499) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
